occupancy_reader: RTL and testbench
===================================

# occupancy_reader

Read-side streamer for the occupancy grid. On `start`, it walks all 512 cells of the 32×16 grid in raster order and issues reads to the grid memory's synchronous read port. Each returned cell byte goes out on a valid/ready stream tagged with its coordinates, for the scan matcher or host dump path. It pauses while the writer side reports `grid_busy` and absorbs consumer backpressure with a 2-entry buffer.

## Interface
- `X_WIDTH`, default 5: x coordinate width (32 columns)
- `Y_WIDTH`, default 4: y coordinate width (16 rows)
- `DATA_WIDTH`, default 8: cell byte width
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin full-grid dump; sampled only in IDLE
- `grid_busy` in 1: writer/zeroing in progress; no reads may be issued while high
- `rd_en` out 1: read strobe to grid memory
- `rd_x` out X_WIDTH: read column
- `rd_y` out Y_WIDTH: read row
- `rd_data` in DATA_WIDTH: grid byte, valid exactly 1 cycle after `rd_en`
- `out_valid` out 1: stream beat available
- `out_ready` in 1: consumer accepts beat
- `out_data` out DATA_WIDTH: cell byte
- `out_x`, `out_y` out X_WIDTH/Y_WIDTH: coordinates of `out_data`
- `out_last` out 1: beat is cell (31,15)
- `busy` out 1: dump in progress (state ≠ IDLE)
- `done` out 1: one-cycle pulse after last beat handshakes

## Operation
- States: IDLE, WAIT_GRID, STREAM, DRAIN.
- IDLE: `start`=1 → STREAM if `grid_busy`=0, else WAIT_GRID. Cursor cleared to (0,0).
- WAIT_GRID: stays until `grid_busy`=0, then → STREAM.
- STREAM: `rd_en` = !grid_busy && (fifo_count + inflight − pop) < 2, where pop = out_valid && out_ready and inflight = `rd_en` of the previous cycle.
  - Each issued read advances the cursor: x increments; at x=31, x wraps to 0 and y increments.
  - Issuing (31,15) → DRAIN.
- DRAIN: no reads; when the buffer is empty and inflight=0 → IDLE with `done`=1 for one cycle.
- `rd_data` is written into the buffer with its coordinates in the cycle it is valid. The buffer is never overrun by construction; an overrun is an assertion failure.
- `grid_busy` rising mid-STREAM: no new reads; an in-flight read still completes and is buffered; the stream continues draining. Reads resume when `grid_busy` falls, with no duplicated or skipped cells.
- `start` outside IDLE is ignored.
- `out_valid` is held until handshaken. `out_data`, `out_x`, `out_y` and `out_last` are stable while `out_valid` is high and `out_ready` is low.
- Reset mid-dump: returns to IDLE, buffer and cursor cleared, in-flight read discarded; no `done`.

## Timing
- Reset values: `rd_en`=0, `rd_x`=0, `rd_y`=0, `out_valid`=0, `out_data`=0, `out_x`=0, `out_y`=0, `out_last`=0, `busy`=0, `done`=0.
- With `start` sampled at edge N and `grid_busy`=0:
  - `rd_en` is high in cycle N+1 for (0,0).
  - `rd_data` is valid in N+2.
  - `out_valid` goes high in N+3.
- Throughput is 1 beat/cycle with `out_ready` held high. The last handshake is at N+514; `done` is high in N+515; `busy` is low from N+515.
- `busy` goes high the cycle after `start` is sampled.

## Structure
- `occupancy_pkg`:
  - `X_WIDTH`/`Y_WIDTH`/`DATA_WIDTH` defaults and `GRID_CELLS`=512.
  - Reader state enum `reader_state_t`.
  - Packed beat struct {data, x, y, last}.
- Sub-module `occupancy_reader_fifo`: 2-entry registered FIFO of the beat struct, exposing count, push, pop, head.
- Top: FSM, cursor counters and issue logic.

## Test plan
- `out_ready`=1, `grid_busy`=0, grid preloaded with data = {y,x[3:0]} pattern → 512 beats in raster order. The first beat is (0,0) at N+3, the last is (31,15) with `out_last`=1, and `done` pulses at N+515.
- `out_ready` toggling 1/0 each cycle → no lost or duplicate beats, payload stable while stalled, `rd_en` never high when the buffer plus inflight would exceed 2.
- `start` with `grid_busy`=1 for 10 cycles → WAIT_GRID, no `rd_en`. The first read comes 1 cycle after `grid_busy` falls.
- `grid_busy` pulsed for 5 cycles at cursor (31,3) → in-flight (31,3) is delivered, then (0,4) follows after resume, with a correct row wrap.
- `reset` asserted at beat 100 → all outputs at reset values next cycle, no `done`. A fresh `start` restarts at (0,0).
- `start` held high during a dump → ignored. A second dump begins only after the `done` cycle when `start` is sampled in IDLE.

Source files
------------

// File: rtl/occupancy_pkg.sv
// Shared types and constants for the occupancy grid read-side streamer.
package occupancy_pkg;

    localparam int X_WIDTH_DEF    = 5;
    localparam int Y_WIDTH_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int GRID_CELLS     = 512;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_GRID,
        ST_STREAM,
        ST_DRAIN
    } reader_state_t;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] data;
        logic [X_WIDTH_DEF-1:0]    x;
        logic [Y_WIDTH_DEF-1:0]    y;
        logic                      last;
    } beat_t;

endpackage

// File: rtl/occupancy_reader_fifo.sv
// Two-entry registered FIFO holding returned cell beats until the consumer takes them.
module occupancy_reader_fifo
    import occupancy_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output beat_t      head,
    output logic [1:0] count
);

    beat_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

    // The issue logic upstream guarantees room for every in-flight read.
    overrun_chk: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && count == 2'd2));

endmodule

// File: rtl/occupancy_reader.sv
// Walks the 32x16 occupancy grid in raster order and streams each cell byte
// with its coordinates over a valid/ready interface.
module occupancy_reader
    import occupancy_pkg::*;
#(
    parameter int X_WIDTH    = X_WIDTH_DEF,
    parameter int Y_WIDTH    = Y_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  grid_busy,
    output logic                  rd_en,
    output logic [X_WIDTH-1:0]    rd_x,
    output logic [Y_WIDTH-1:0]    rd_y,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [X_WIDTH-1:0]    out_x,
    output logic [Y_WIDTH-1:0]    out_y,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    reader_state_t      state;
    logic [X_WIDTH-1:0] cur_x;
    logic [Y_WIDTH-1:0] cur_y;
    logic               cur_last;

    logic               vld_p1;
    logic [X_WIDTH-1:0] x_p1;
    logic [Y_WIDTH-1:0] y_p1;

    logic [1:0]         fifo_count;
    logic               fifo_pop;
    logic [2:0]         pending;
    logic               drain_empty;
    beat_t              push_beat;
    beat_t              head_beat;

    assign out_valid = (fifo_count != 2'd0);
    assign fifo_pop  = out_valid && out_ready;

    // Slots the buffer would still owe after this cycle: buffered + returning - leaving.
    assign pending   = 3'(fifo_count) + 3'(vld_p1) - 3'(fifo_pop);
    assign rd_en     = (state == ST_STREAM) && !grid_busy && (pending < 3'd2);
    assign rd_x      = cur_x;
    assign rd_y      = cur_y;
    assign cur_last  = (cur_x == '1) && (cur_y == '1);

    // The dump is finished once nothing is returning and the buffer empties this cycle.
    assign drain_empty = !vld_p1 &&
                         ((fifo_count == 2'd0) || (fifo_count == 2'd1 && fifo_pop));

    assign busy = (state != ST_IDLE);

    // Stage p1: read data returns from memory and is captured with its coordinates.
    always_comb begin
        push_beat      = '0;
        push_beat.data = rd_data;
        push_beat.x    = x_p1;
        push_beat.y    = y_p1;
        push_beat.last = (x_p1 == '1) && (y_p1 == '1);
    end

    occupancy_reader_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (vld_p1),
        .push_beat (push_beat),
        .pop       (fifo_pop),
        .head      (head_beat),
        .count     (fifo_count)
    );

    assign out_data = head_beat.data;
    assign out_x    = head_beat.x;
    assign out_y    = head_beat.y;
    assign out_last = head_beat.last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            cur_x  <= '0;
            cur_y  <= '0;
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
            done   <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_p1 <= rd_en;
            if (rd_en) begin
                x_p1  <= cur_x;
                y_p1  <= cur_y;
                cur_x <= cur_x + 1'b1;
                if (cur_x == '1) begin
                    cur_y <= cur_y + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_x <= '0;
                        cur_y <= '0;
                        state <= grid_busy ? ST_WAIT_GRID : ST_STREAM;
                    end
                end
                ST_WAIT_GRID: begin
                    if (!grid_busy) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (rd_en && cur_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_occupancy_reader.sv
// Bench for occupancy_reader: table-driven full dumps plus hand-written corner sequences,
// with a raster-order scoreboard checked at every output handshake.
module tb_occupancy_reader;

    localparam int XW = 5;
    localparam int YW = 4;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          grid_busy;
    logic          rd_en;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    occupancy_reader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .grid_busy (grid_busy),
        .rd_en     (rd_en),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Grid memory model: synchronous read of the {y, x[3:0]} pattern, noise otherwise.
    always @(posedge clock) begin
        rd_data <= rd_en ? {rd_y, rd_x[3:0]} : DW'($urandom);
    end

    typedef struct {
        logic [DW-1:0] d;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          last;
    } exp_t;

    typedef struct {
        int ready_mode;
        int busy_pre;
        int exp_first_rd;
        int exp_first_vld;
        int exp_done;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[4];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_edge = 0;
    int ready_mode = 0;
    int first_rd_rel = -1;
    int first_vld_rel = -1;
    int done_rel = -1;
    int done_cnt = 0;
    int hs_cnt = 0;
    int issued = 0;
    int last_hs_rel = -1;
    int busy_at1 = 0;
    int rd_rise_rel = -1;
    int busy_viol = 0;
    int over_viol = 0;
    int resume_x = -1;
    int resume_y = -1;
    bit prev_rd = 0;
    bit stalled_prev = 0;
    bit want_resume = 0;
    bit hit_313 = 0;
    logic [17:0] saved = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        int rel;
        bit pop;
        exp_t e;
        rel = cyc - n_edge + 1;
        pop = out_valid && out_ready;
        if (rd_en) begin
            if (grid_busy) busy_viol++;
            if ((issued - hs_cnt) - int'(pop) >= 2) over_viol++;
            if (first_rd_rel < 0) first_rd_rel = rel;
            if (!prev_rd) rd_rise_rel = rel;
            if (want_resume) begin
                resume_x = int'(rd_x);
                resume_y = int'(rd_y);
                want_resume = 0;
            end
            if (rd_x == 5'd31 && rd_y == 4'd3) hit_313 = 1;
            issued++;
        end
        prev_rd = rd_en;
        if (out_valid && first_vld_rel < 0) first_vld_rel = rel;
        if (rel == 1) busy_at1 = int'(busy);
        if (stalled_prev) begin
            check("stall_hold", {out_valid, out_data, out_x, out_y, out_last}, {1'b1, saved});
        end
        stalled_prev = out_valid && !out_ready;
        saved = {out_data, out_x, out_y, out_last};
        if (pop) begin
            hs_cnt++;
            last_hs_rel = rel;
            check("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("beat_payload", {out_data, out_x, out_y, out_last}, {e.d, e.x, e.y, e.last});
            end
        end
        if (done) begin
            done_cnt++;
            done_rel = rel;
            check("busy_low_at_done", busy, 0);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        cyc++;
        if (ready_mode == 1) out_ready = ~out_ready;
        else out_ready = 1'b1;
    endtask

    task automatic arm();
        exp_t e;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 32; x++) begin
                e.d = DW'((y << 4) | (x & 15));
                e.x = XW'(x);
                e.y = YW'(y);
                e.last = (x == 31) && (y == 15);
                exp_q.push_back(e);
            end
        end
        first_rd_rel = -1;
        first_vld_rel = -1;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {rd_en, rd_x, rd_y, out_valid, out_data, out_x, out_y, out_last, busy, done}, 0);
    endtask

    task automatic run_dump(input vec_t v);
        int d0;
        int h0;
        ready_mode = v.ready_mode;
        out_ready = 1'b1;
        grid_busy = (v.busy_pre > 0);
        start = 1'b1;
        arm();
        d0 = done_cnt;
        h0 = hs_cnt;
        tick();
        n_edge = cyc;
        start = 1'b0;
        for (int k = 0; k < 4000 && done_cnt == d0; k++) begin
            if (cyc - n_edge >= v.busy_pre - 1) grid_busy = 1'b0;
            tick();
        end
        check("first_rd_cycle", first_rd_rel, v.exp_first_rd);
        check("first_valid_cycle", first_vld_rel, v.exp_first_vld);
        check("busy_after_start", busy_at1, 1);
        check("done_seen", done_cnt - d0, 1);
        check("beat_count", hs_cnt - h0, 512);
        check("queue_empty", exp_q.size(), 0);
        if (v.exp_done != 0) begin
            check("done_cycle", done_rel, v.exp_done);
            check("last_handshake_cycle", last_hs_rel, v.exp_done - 1);
        end
        ready_mode = 0;
        for (int k = 0; k < 3; k++) tick();
        check("done_single_pulse", done_cnt - d0, 1);
        check("idle_after_dump", busy, 0);
        exp_q.delete();
    endtask

    initial begin
        int d0;
        int h0;
        int dr;

        vecs[0] = '{ready_mode: 0, busy_pre: 0,  exp_first_rd: 1,  exp_first_vld: 3,  exp_done: 515};
        vecs[1] = '{ready_mode: 1, busy_pre: 0,  exp_first_rd: 1,  exp_first_vld: 3,  exp_done: 0};
        vecs[2] = '{ready_mode: 0, busy_pre: 10, exp_first_rd: 11, exp_first_vld: 13, exp_done: 525};
        vecs[3] = '{ready_mode: 1, busy_pre: 3,  exp_first_rd: 4,  exp_first_vld: 6,  exp_done: 0};

        reset = 1'b1;
        start = 1'b0;
        grid_busy = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset_values");
        reset = 1'b0;
        tick();
        check_reset_outputs("idle_values");

        for (int i = 0; i < 4; i++) run_dump(vecs[i]);

        // grid_busy pulse right after (31,3) is issued
        ready_mode = 0;
        start = 1'b1;
        arm();
        hit_313 = 0;
        d0 = done_cnt;
        h0 = hs_cnt;
        tick();
        n_edge = cyc;
        start = 1'b0;
        for (int k = 0; k < 1000 && !hit_313; k++) tick();
        check("reached_31_3", hit_313, 1);
        grid_busy = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        grid_busy = 1'b0;
        want_resume = 1;
        for (int k = 0; k < 2000 && done_cnt == d0; k++) tick();
        check("resume_x", resume_x, 0);
        check("resume_y", resume_y, 4);
        check("pulse_done_seen", done_cnt - d0, 1);
        check("pulse_beat_count", hs_cnt - h0, 512);
        check("pulse_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        for (int k = 0; k < 3; k++) tick();

        // reset in the middle of a dump
        start = 1'b1;
        arm();
        d0 = done_cnt;
        h0 = hs_cnt;
        tick();
        n_edge = cyc;
        start = 1'b0;
        for (int k = 0; k < 2000 && hs_cnt - h0 < 100; k++) tick();
        check("reached_beat_100", hs_cnt - h0, 100);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid_dump_reset_values");
        reset = 1'b0;
        exp_q.delete();
        issued = hs_cnt;
        stalled_prev = 0;
        prev_rd = 0;
        for (int k = 0; k < 5; k++) tick();
        check("no_done_after_reset", done_cnt - d0, 0);
        check("idle_after_reset", busy, 0);
        run_dump(vecs[0]);

        // start held high across a dump: next dump only after the done cycle
        ready_mode = 0;
        start = 1'b1;
        arm();
        d0 = done_cnt;
        h0 = hs_cnt;
        tick();
        n_edge = cyc;
        for (int k = 0; k < 2000 && done_cnt == d0; k++) tick();
        check("held_start_first_done", done_cnt - d0, 1);
        dr = done_rel;
        check("held_start_done_cycle", dr, 515);
        arm();
        tick();
        tick();
        check("restart_after_done", rd_rise_rel, dr + 1);
        start = 1'b0;
        for (int k = 0; k < 2000 && done_cnt == d0 + 1; k++) tick();
        check("held_start_second_done", done_cnt - d0, 2);
        check("held_start_beats", hs_cnt - h0, 1024);
        check("held_start_queue_empty", exp_q.size(), 0);

        check("rd_while_grid_busy", busy_viol, 0);
        check("rd_beyond_buffer", over_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
